// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths, opcode
// field position, halt opcode and FSM state encodings.
package instruction_fetch_pkg;

    localparam int ADDR_W_DEF  = 10;
    localparam int INSTR_W_DEF = 16;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;

    localparam logic [2:0] HALT_OP_DEF = 3'b111;

    localparam logic [1:0] ST_START  = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    function automatic logic is_halt(input logic [2:0] opc, input logic [2:0] halt_op);
        return (opc == halt_op);
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Single-stage instruction fetch: PC register, one-entry output register with
// valid/ready handshake, redirect flush and halt-on-opcode.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_START  | first cycle after reset, no capture
// ST_RUN    | fetching one instruction per cycle when not stalled
// ST_HALTED | halt opcode captured, PC frozen, output drains
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int               ADDR_W   = ADDR_W_DEF,
    parameter int               INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [2:0]       HALT_OP  = HALT_OP_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              accept;
    logic              capture;
    logic              halt_hit;

    assign imem_addr = pc;
    // Natural ADDR_W-bit overflow gives the required wrap to address 0.
    assign pc_next   = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign accept    = out_valid & out_ready;
    assign capture   = (state == ST_RUN) & (~out_valid | out_ready) & ~redirect_valid;
    assign halt_hit  = is_halt(imem_instr[OPC_HI:OPC_LO], HALT_OP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_START;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            halted    <= 1'b0;
        end else if (redirect_valid) begin
            // Flush wins over capture and stall; a held instruction accepted
            // this cycle is simply dropped from the register.
            state     <= ST_RUN;
            pc        <= redirect_pc;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            if (capture) begin
                out_instr <= imem_instr;
                out_pc    <= pc;
                out_valid <= 1'b1;
                if (halt_hit) begin
                    state  <= ST_HALTED;
                    halted <= 1'b1;
                end else begin
                    pc <= pc_next;
                end
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (state == ST_START) begin
                state <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a vector table for the basic
// stream/stall/redirect behaviour plus directed wrap, halt and reset sequences.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  imem_addr;
    logic [15:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [9:0]  out_pc;
    logic        halted;

    logic [15:0] mem [1024];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr];

    instruction_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    typedef struct {
        logic        rst;
        logic        rv;
        logic [9:0]  rpc;
        logic        rdy;
        logic        ev;
        logic [9:0]  epc;
        logic [15:0] einstr;
        logic [9:0]  eaddr;
        logic        eh;
    } vec_t;

    vec_t vt [17];

    function automatic vec_t mk(logic r, logic rv, logic [9:0] rpc, logic rdy,
                                logic ev, logic [9:0] epc, logic [15:0] ei,
                                logic [9:0] ea, logic eh);
        vec_t v;
        v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.einstr = ei; v.eaddr = ea; v.eh = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [9:0] epc,
                             input logic [15:0] ei, input logic [9:0] ea, input logic eh);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".out_pc"},    32'(out_pc),    32'(epc));
        chk({tag, ".out_instr"}, 32'(out_instr), 32'(ei));
        chk({tag, ".imem_addr"}, 32'(imem_addr), 32'(ea));
        chk({tag, ".halted"},    32'(halted),    32'(eh));
    endtask

    task automatic step(input logic r, input logic rv, input logic [9:0] rpc, input logic rdy);
        @(negedge clk);
        rst = r;
        redirect_valid = rv;
        redirect_pc = rpc;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 | 16'(i);
        mem[5] = 16'hE005;

        // reset, stream 0..3, reset, stall 3 cycles, stall + redirect to 0x200
        vt[0]  = mk(1, 0, 10'h000, 1, 0, 10'h000, 16'h0000, 10'h000, 0);
        vt[1]  = mk(1, 0, 10'h000, 1, 0, 10'h000, 16'h0000, 10'h000, 0);
        vt[2]  = mk(0, 0, 10'h000, 1, 0, 10'h000, 16'h0000, 10'h000, 0);
        vt[3]  = mk(0, 0, 10'h000, 1, 1, 10'h000, 16'h1000, 10'h001, 0);
        vt[4]  = mk(0, 0, 10'h000, 1, 1, 10'h001, 16'h1001, 10'h002, 0);
        vt[5]  = mk(0, 0, 10'h000, 1, 1, 10'h002, 16'h1002, 10'h003, 0);
        vt[6]  = mk(0, 0, 10'h000, 1, 1, 10'h003, 16'h1003, 10'h004, 0);
        vt[7]  = mk(1, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 10'h000, 0);
        vt[8]  = mk(0, 0, 10'h000, 0, 0, 10'h000, 16'h0000, 10'h000, 0);
        vt[9]  = mk(0, 0, 10'h000, 0, 1, 10'h000, 16'h1000, 10'h001, 0);
        vt[10] = mk(0, 0, 10'h000, 0, 1, 10'h000, 16'h1000, 10'h001, 0);
        vt[11] = mk(0, 0, 10'h000, 0, 1, 10'h000, 16'h1000, 10'h001, 0);
        vt[12] = mk(0, 0, 10'h000, 0, 1, 10'h000, 16'h1000, 10'h001, 0);
        vt[13] = mk(0, 0, 10'h000, 1, 1, 10'h001, 16'h1001, 10'h002, 0);
        vt[14] = mk(0, 0, 10'h000, 0, 1, 10'h001, 16'h1001, 10'h002, 0);
        vt[15] = mk(0, 1, 10'h200, 0, 0, 10'h001, 16'h1001, 10'h200, 0);
        vt[16] = mk(0, 0, 10'h000, 0, 1, 10'h200, 16'h1200, 10'h201, 0);

        for (int i = 0; i < 17; i++) begin
            step(vt[i].rst, vt[i].rv, vt[i].rpc, vt[i].rdy);
            check_all($sformatf("vec%0d", i), vt[i].ev, vt[i].epc, vt[i].einstr,
                      vt[i].eaddr, vt[i].eh);
        end

        // PC wrap: redirect to 1023, then 1023, 0, 1
        step(0, 1, 10'h3FF, 1);
        check_all("wrap_redir", 0, 10'h200, 16'h1200, 10'h3FF, 0);
        step(0, 0, 10'h000, 1);
        check_all("wrap_1023", 1, 10'h3FF, 16'h13FF, 10'h000, 0);
        step(0, 0, 10'h000, 1);
        check_all("wrap_0", 1, 10'h000, 16'h1000, 10'h001, 0);
        step(0, 0, 10'h000, 1);
        check_all("wrap_1", 1, 10'h001, 16'h1001, 10'h002, 0);

        // halt on word 5, drain, then resume via redirect to 0
        step(1, 0, 10'h000, 1);
        step(0, 0, 10'h000, 1);
        check_all("halt_start", 0, 10'h000, 16'h0000, 10'h000, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 10'h000, 1);
            check_all($sformatf("halt_run%0d", k), 1, 10'(k), mem[k],
                      (k == 5) ? 10'd5 : 10'(k + 1), (k == 5));
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 10'h000, 1);
            check_all($sformatf("halt_idle%0d", k), 0, 10'd5, 16'hE005, 10'd5, 1);
        end
        step(0, 1, 10'h000, 1);
        check_all("halt_redir", 0, 10'd5, 16'hE005, 10'h000, 0);
        step(0, 0, 10'h000, 0);
        check_all("halt_resume", 1, 10'h000, 16'h1000, 10'h001, 0);

        // redirect with out_ready in the same cycle still flushes
        step(0, 1, 10'h300, 1);
        check_all("redir_rdy", 0, 10'h000, 16'h1000, 10'h300, 0);

        // reset with simultaneous redirect while stalled holding an instruction
        step(0, 0, 10'h000, 0);
        check_all("stall_cap", 1, 10'h300, 16'h1300, 10'h301, 0);
        step(0, 0, 10'h000, 0);
        check_all("stall_hold", 1, 10'h300, 16'h1300, 10'h301, 0);
        step(1, 1, 10'h155, 0);
        check_all("rst_over_redir", 0, 10'h000, 16'h0000, 10'h000, 0);

        // reset while halted clears halted
        step(0, 0, 10'h000, 1);
        for (int k = 0; k < 6; k++) step(0, 0, 10'h000, 1);
        check_all("pre_rst_halt", 1, 10'd5, 16'hE005, 10'd5, 1);
        step(1, 1, 10'h0AA, 0);
        check_all("rst_in_halt", 0, 10'h000, 16'h0000, 10'h000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter ADDR_W, default 10, instruction address width in words (1024-word space).
REQ-002 Parameter INSTR_W, default 16, instruction width.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 Parameter HALT_OP, default 3'b111, opcode field value that stops fetching.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 imem_addr  output  ADDR_W  word address driven to the instruction memory; equals the PC register.
REQ-008 imem_instr  input  INSTR_W  instruction returned combinationally for imem_addr in the same cycle.
REQ-009 redirect_valid  input  1  branch/jump redirect from execute; one-cycle pulse.
REQ-010 redirect_pc  input  ADDR_W  target word address, sampled when redirect_valid=1.
REQ-011 out_valid  output  1  out_instr/out_pc hold a valid fetched instruction.
REQ-012 out_ready  input  1  decode accepts the instruction this cycle.
REQ-013 out_instr  output  INSTR_W  registered fetched instruction.
REQ-014 out_pc  output  ADDR_W  registered address of out_instr.
REQ-015 halted  output  1  fetch has stopped on HALT_OP.

Function
REQ-016 States: START (one cycle after reset, no capture), RUN (fetching), HALTED (no fetch).
REQ-017 Transfer: accept = out_valid & out_ready; capture = (state==RUN) & (~out_valid | out_ready) & ~redirect_valid.
REQ-018 On capture: out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+1.
REQ-019 Accept without capture clears out_valid; no capture and no accept leaves out_* and pc unchanged (stall, out_instr/out_pc stable).
REQ-020 PC increment wraps modulo 2^ADDR_W: 1023 -> 0, no flag.
REQ-021 Throughput one instruction per cycle while out_ready=1; latency from pc to out_valid is exactly one cycle.
REQ-022 Capture of instruction with imem_instr[15:13]==HALT_OP: instruction is still presented; pc does not increment; state -> HALTED; halted=1 from next cycle.
REQ-023 redirect_valid=1 (any state): pc<=redirect_pc, out_valid<=0 (flush, overrides capture and stall), state -> RUN, halted<=0.
REQ-024 Redirect and out_ready in the same cycle: the held instruction counts as accepted by decode; flush still applies.
REQ-025 HALTED: imem_addr holds the halt address; out_valid drains normally via out_ready; leaves only on redirect or rst.
REQ-026 START -> RUN unconditionally after one cycle unless redirect_valid=1, which takes precedence per REQ-023.

Reset
REQ-027 rst=1 at any edge: pc<=RESET_PC, out_valid<=0, out_instr<=0, out_pc<=0, halted<=0, state<=START; overrides redirect and capture, including mid-stall or mid-halt.

Structure
REQ-028 Shared package holds ADDR_W/INSTR_W defaults, opcode field position [15:13], HALT_OP and the state enumeration.
REQ-029 Single module; pc/state logic and the output register in one block, no sub-module.

Verification
REQ-030 Reset, out_ready=1, memory words 0..3 -> out_pc 0,1,2,3 on consecutive cycles, first out_valid two cycles after rst deasserts.
REQ-031 out_ready=0 for 3 cycles after first capture -> out_instr/out_pc frozen at word 0, imem_addr stays 1; release -> word 1 next cycle.
REQ-032 redirect_valid with redirect_pc=0x200 while out_valid=1, out_ready=0 -> out_valid=0 next cycle, then out_pc=0x200 the cycle after.
REQ-033 HALT_OP at word 5 -> word 5 presented, halted=1, imem_addr stays 5, no further out_valid; redirect to 0 resumes from word 0.
REQ-034 redirect_pc=1023, out_ready=1 -> out_pc sequence 1023, 0, 1.
REQ-035 rst asserted while stalled with out_valid=1 and simultaneous redirect -> next cycle out_valid=0, pc=RESET_PC, halted=0.
